// File: rtl/gearbox_pkg.sv
// Shared state encoding and byte-mask helper for the generic byte gearbox.
package gearbox_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int MAX_BYTES = 64;

    // Mask with the low n bits set; n saturates at MAX_BYTES.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int n);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gearbox_rst_sync.sv
// Reset synchroniser: asserts immediately, releases two clk edges after reset falls.
module gearbox_rst_sync (
    input  logic clk,
    input  logic reset,
    output logic rst_out
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], 1'b0};
        end
    end

    assign rst_out = sync_reg[1];

endmodule

// File: rtl/gearbox_generic.sv
// Byte gearbox IN_W -> OUT_W with frame flush and keep mask.
// Define GEARBOX_GENERIC_RST_SYNC_EN to route reset through a 2-flop synchroniser.
module gearbox_generic
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic [OUT_W/8-1:0] m_keep,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready
);

    localparam int IN_B  = IN_W / 8;
    localparam int OUT_B = OUT_W / 8;
    localparam int BUF_B = IN_B + OUT_B;
    localparam int BUF_W = BUF_B * 8;
    localparam int FW    = $clog2(BUF_B + 1);

    logic rst;

`ifdef GEARBOX_GENERIC_RST_SYNC_EN
    gearbox_rst_sync u_rst_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_out (rst)
    );
`else
    assign rst = reset;
`endif

    state_t           state_reg, state_next;
    logic [FW-1:0]    fill_reg, fill_next;
    logic [BUF_W-1:0] buf_reg, buf_next;
    logic             m_valid_reg, m_valid_next;
    logic             m_last_reg, m_last_next;
    logic [OUT_B-1:0] m_keep_reg, m_keep_next;
    logic             in_xfer, out_xfer;
    int               fill_i, take_i, fill_next_i;

    assign out_xfer = m_valid_reg && m_ready;
    assign in_xfer  = s_valid && s_ready;

    always_comb begin
        fill_i = int'(fill_reg);
        take_i = 0;
        if (out_xfer) take_i = (fill_i >= OUT_B) ? OUT_B : fill_i;
        s_ready = !rst && (state_reg == FILL) && (fill_i - take_i + IN_B <= BUF_B);
    end

    // Bytes at and above fill_reg are always zero, so appending is a plain OR
    // and the low OUT_W bits already form the zero-padded output word.
    always_comb begin
        buf_next    = out_xfer ? (buf_reg >> OUT_W) : buf_reg;
        fill_next_i = fill_i - take_i;
        if (in_xfer) begin
            buf_next    = buf_next | (BUF_W'(s_data) << (8 * fill_next_i));
            fill_next_i = fill_next_i + IN_B;
        end
        fill_next = FW'(fill_next_i);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (in_xfer && s_last) state_next = FLUSH;
            FLUSH:   if (out_xfer && fill_next_i == 0) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        m_valid_next = (fill_next_i >= OUT_B) || (state_next == FLUSH && fill_next_i > 0);
        m_last_next  = m_valid_next && (state_next == FLUSH) && (fill_next_i <= OUT_B);
        m_keep_next  = '0;
        if (m_valid_next) begin
            m_keep_next = OUT_B'(keep_mask((fill_next_i >= OUT_B) ? OUT_B : fill_next_i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FILL;
            fill_reg    <= '0;
            buf_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_keep_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            fill_reg    <= fill_next;
            buf_reg     <= buf_next;
            m_valid_reg <= m_valid_next;
            m_last_reg  <= m_last_next;
            m_keep_reg  <= m_keep_next;
        end
    end

    assign m_data  = buf_reg[OUT_W-1:0];
    assign m_keep  = m_keep_reg;
    assign m_valid = m_valid_reg;
    assign m_last  = m_last_reg;

endmodule

// File: tb/tb_gearbox_generic.sv
// Randomised and directed check of gearbox_generic (24->32 and 32->24) against a byte-queue model.
module tb_gearbox_generic;

`ifdef GEARBOX_GENERIC_RST_SYNC_EN
    localparam int RST_LAT = 2;
`else
    localparam int RST_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [23:0] a_s_data;
    logic        a_s_valid, a_s_last, a_s_ready;
    logic [31:0] a_m_data;
    logic [3:0]  a_m_keep;
    logic        a_m_valid, a_m_last, a_m_ready;

    logic [31:0] b_s_data;
    logic        b_s_valid, b_s_last, b_s_ready;
    logic [23:0] b_m_data;
    logic [2:0]  b_m_keep;
    logic        b_m_valid, b_m_last, b_m_ready;

    gearbox_generic #(.IN_W(24), .OUT_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_last(a_s_last), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_keep(a_m_keep), .m_valid(a_m_valid), .m_last(a_m_last),
        .m_ready(a_m_ready)
    );

    gearbox_generic #(.IN_W(32), .OUT_W(24)) dut_b (
        .clk(clk), .reset(reset),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_keep(b_m_keep), .m_valid(b_m_valid), .m_last(b_m_last),
        .m_ready(b_m_ready)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] feed  [2][$];   // {last, data}
    logic [8:0]  mq    [2][$];   // bytes inside the DUT: {frame_end, byte}
    logic [36:0] lit_q [2][$];   // {last, keep, data}
    int          vprob;
    int          rdy_mode [2];   // 0 always ready, 1 random, 2 held low
    int          rel_cnt;
    logic        prev_stall [2];
    logic [36:0] prev_out   [2];

    function automatic int ib(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    function automatic int ob(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic idle();
        return feed[0].size() == 0 && feed[1].size() == 0 && mq[0].size() == 0 && mq[1].size() == 0;
    endfunction

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL inst%0d %s @%0t: got %0h, expected %0h", k, name, $time, act, exp_v);
        end
    endtask

    task automatic push_word(input int k, input logic [31:0] d, input logic l);
        feed[k].push_back({l, d});
    endtask

    task automatic lit(input int k, input logic [31:0] d, input logic [3:0] kp, input logic l);
        lit_q[k].push_back({l, kp, d});
    endtask

    task automatic gen(input int k, input int frames);
        for (int f = 0; f < frames; f++) begin
            int len;
            len = int'($urandom_range(6, 1));
            for (int w = 0; w < len; w++) push_word(k, $urandom, w == len - 1);
        end
    endtask

    // One clock cycle: drive at edge+1, check at edge+2, advance the model at the next edge.
    task automatic tick();
        logic [31:0] sd [2];
        logic [31:0] md [2];
        logic [3:0]  mk [2];
        logic        sv [2], sl [2], sr [2], mv [2], ml [2], mr [2];
        logic        in_x [2], out_x [2];
        int          take [2];
        logic        rst_int;
        for (int k = 0; k < 2; k++) begin
            sv[k] = (feed[k].size() > 0) && (int'($urandom_range(99)) < vprob);
            sd[k] = sv[k] ? feed[k][0][31:0] : 32'h0;
            sl[k] = sv[k] ? feed[k][0][32] : 1'b0;
            mr[k] = (rdy_mode[k] == 0) || (rdy_mode[k] == 1 && $urandom_range(99) < 60);
        end
        a_s_valid = sv[0]; a_s_data = sd[0][23:0]; a_s_last = sl[0]; a_m_ready = mr[0];
        b_s_valid = sv[1]; b_s_data = sd[1];       b_s_last = sl[1]; b_m_ready = mr[1];
        #1;
        md[0] = a_m_data;  md[1] = {8'h00, b_m_data};
        mk[0] = a_m_keep;  mk[1] = {1'b0, b_m_keep};
        mv[0] = a_m_valid; mv[1] = b_m_valid;
        ml[0] = a_m_last;  ml[1] = b_m_last;
        sr[0] = a_s_ready; sr[1] = b_s_ready;
        rst_int = reset || (rel_cnt < RST_LAT);
        for (int k = 0; k < 2; k++) begin
            int          fill, n;
            logic        has_last, exp_v, exp_r, el;
            logic [31:0] ew, ek;
            if (rst_int) begin
                mq[k].delete();
                prev_stall[k] = 1'b0;
            end
            fill = mq[k].size();
            has_last = 1'b0;
            for (int i = 0; i < fill; i++) if (mq[k][i][8]) has_last = 1'b1;
            exp_v = !rst_int && (fill >= ob(k) || (has_last && fill > 0));
            exp_r = !rst_int && !has_last &&
                    (fill - ((exp_v && mr[k]) ? ob(k) : 0) + ib(k) <= ib(k) + ob(k));
            n = 0; ew = '0; el = 1'b0;
            if (exp_v) begin
                for (int i = 0; i < ob(k) && i < fill && !el; i++) begin
                    ew = ew | (32'(mq[k][i][7:0]) << (8 * i));
                    el = mq[k][i][8];
                    n++;
                end
            end
            ek = (32'd1 << n) - 32'd1;
            chk(k, "fill_within_buffer", fill <= ib(k) + ob(k), 1);
            chk(k, "s_ready", sr[k], exp_r);
            chk(k, "m_valid", mv[k], exp_v);
            if (exp_v) begin
                chk(k, "m_data", md[k], ew);
                chk(k, "m_keep", mk[k], ek);
                chk(k, "m_last", ml[k], el);
            end else if (rst_int) begin
                chk(k, "rst_m_data", md[k], 0);
                chk(k, "rst_m_keep", mk[k], 0);
                chk(k, "rst_m_last", ml[k], 0);
            end
            if (prev_stall[k] && !rst_int) chk(k, "hold_while_stalled", {ml[k], mk[k], md[k]}, prev_out[k]);
            prev_stall[k] = mv[k] && !mr[k];
            prev_out[k]   = {ml[k], mk[k], md[k]};
            in_x[k]  = sv[k] && sr[k];
            out_x[k] = mv[k] && mr[k];
            take[k]  = n;
            if (out_x[k]) begin
                $display("[TB] inst%0d word data=%08h keep=%h last=%0b", k, md[k], mk[k], ml[k]);
                if (lit_q[k].size() > 0) begin
                    logic [36:0] l;
                    l = lit_q[k].pop_front();
                    chk(k, "literal_dut", {ml[k], mk[k], md[k]}, l);
                    chk(k, "literal_model", {el, ek[3:0], ew}, l);
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (out_x[k]) repeat (take[k]) void'(mq[k].pop_front());
            if (in_x[k]) begin
                for (int i = 0; i < ib(k); i++) mq[k].push_back({sl[k] && i == ib(k) - 1, sd[k][8*i +: 8]});
                void'(feed[k].pop_front());
            end
        end
        if (reset) rel_cnt = 0;
        else if (rel_cnt < 8) rel_cnt++;
        #1;
    endtask

    task automatic run_idle(input int budget);
        int c;
        c = 0;
        while (!idle() && c < budget) begin
            tick();
            c++;
        end
        chk(0, "drain_within_budget", idle(), 1);
        tick();
        tick();
        chk(0, "literals_consumed", lit_q[0].size() + lit_q[1].size(), 0);
    endtask

    initial begin
        int blocked;
        reset = 1'b1;
        a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b0;
        vprob = 100; rdy_mode[0] = 0; rdy_mode[1] = 0; rel_cnt = 0;
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        prev_out[0] = '0; prev_out[1] = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        chk(0, "reset_m_valid", a_m_valid, 0);
        chk(0, "reset_s_ready", a_s_ready, 0);
        chk(1, "reset_m_keep", b_m_keep, 0);
        reset = 1'b0;

        // Four 24-bit words packed into three full 32-bit words
        lit(0, 32'h04030201, 4'hF, 1'b0);
        lit(0, 32'h08070605, 4'hF, 1'b0);
        lit(0, 32'h0C0B0A09, 4'hF, 1'b1);
        push_word(0, 32'h030201, 1'b0);
        push_word(0, 32'h060504, 1'b0);
        push_word(0, 32'h090807, 1'b0);
        push_word(0, 32'h0C0B0A, 1'b1);
        run_idle(100);

        lit(0, 32'h00030201, 4'h7, 1'b1);
        push_word(0, 32'h030201, 1'b1);
        run_idle(100);

        lit(0, 32'h04030201, 4'hF, 1'b0);
        lit(0, 32'h00000605, 4'h3, 1'b1);
        push_word(0, 32'h030201, 1'b0);
        push_word(0, 32'h060504, 1'b1);
        run_idle(100);

        lit(1, 32'h00030201, 4'h7, 1'b0);
        lit(1, 32'h00000004, 4'h1, 1'b1);
        push_word(1, 32'h04030201, 1'b1);
        run_idle(100);

        // Back-pressure: 24 bytes in, downstream stalled for five cycles
        for (int i = 0; i < 8; i++) push_word(0, {8'h00, 8'(3*i+3), 8'(3*i+2), 8'(3*i+1)}, i == 7);
        for (int j = 0; j < 6; j++) lit(0, {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)}, 4'hF, j == 5);
        rdy_mode[0] = 2;
        blocked = 0;
        repeat (5) begin
            tick();
            if (!a_s_ready) blocked++;
        end
        chk(0, "stall_backpressure", blocked > 0, 1);
        rdy_mode[0] = 0;
        run_idle(200);

        // Reset in the middle of a frame, then a fresh frame
        rdy_mode[0] = 2;
        push_word(0, 32'h030201, 1'b0);
        push_word(0, 32'h060504, 1'b0);
        repeat (4) tick();
        chk(0, "pre_reset_m_valid", a_m_valid, 1);
        reset = 1'b1;
        feed[0].delete();
        tick();
        chk(0, "midframe_rst_m_valid", a_m_valid, 0);
        chk(0, "midframe_rst_m_last", a_m_last, 0);
        tick();
        reset = 1'b0;
        rdy_mode[0] = 0;
        lit(0, 32'h14131211, 4'hF, 1'b0);
        lit(0, 32'h00001615, 4'h3, 1'b1);
        push_word(0, 32'h131211, 1'b0);
        push_word(0, 32'h161514, 1'b1);
        run_idle(100);

        // Random traffic on both gearboxes with a reset part-way through
        vprob = 70; rdy_mode[0] = 1; rdy_mode[1] = 1;
        gen(0, 30);
        gen(1, 30);
        repeat (300) tick();
        reset = 1'b1;
        feed[0].delete();
        feed[1].delete();
        tick();
        tick();
        reset = 1'b0;
        gen(0, 20);
        gen(1, 20);
        run_idle(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gearbox_generic.md
GEARBOX_GENERIC -- requirements
Module: gearbox_generic

Interface
REQ-001 SHALL have parameter IN_W, default 24, input data width in bits (multiple of 8, 8..256).
REQ-002 SHALL have parameter OUT_W, default 32, output data width in bits (multiple of 8, 8..256).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_data  input  IN_W  input word; byte 0 in bits [7:0] is the earliest byte.
REQ-006 SHALL have port s_valid  input  1  s_data/s_last valid.
REQ-007 SHALL have port s_last  input  1  marks final input word of a frame.
REQ-008 SHALL have port s_ready  output  1  block accepts the word this cycle.
REQ-009 SHALL have port m_data  output  OUT_W  packed output word; byte 0 in bits [7:0].
REQ-010 SHALL have port m_keep  output  OUT_W/8  per-byte valid mask for m_data.
REQ-011 SHALL have port m_valid  output  1  m_data/m_keep/m_last valid.
REQ-012 SHALL have port m_last  output  1  final output word of the frame.
REQ-013 SHALL have port m_ready  input  1  downstream accepts the word this cycle.

Function
REQ-014 SHALL hold bytes in a buffer of BUF_B = (IN_W+OUT_W)/8 bytes with a byte fill count FILL of width clog2(BUF_B+1).
REQ-015 SHALL transfer input on s_valid&&s_ready and output on m_valid&&m_ready; both may occur in the same cycle.
REQ-016 SHALL drive s_ready = (state==FILL) && (FILL - (out transfer ? OUT_W/8 : 0) + IN_W/8 <= BUF_B), with no combinational path from s_valid.
REQ-017 SHALL append accepted bytes above existing buffered bytes, preserving byte order; output always takes the lowest OUT_W/8 bytes.
REQ-018 SHALL use states FILL (accept and emit full words) and FLUSH (entered on an accepted s_last; no input accepted), returning to FILL when the last output word transfers.
REQ-019 SHALL register m_valid: it is asserted when FILL >= OUT_W/8, or in FLUSH when FILL > 0; the first full word appears one cycle after the input that completes it.
REQ-020 SHALL in FLUSH with FILL < OUT_W/8 emit the remaining bytes zero-padded in upper bytes, with m_keep set for exactly FILL low bytes and m_last = 1.
REQ-021 SHALL in FLUSH with the final word exactly full assert m_last on that word, m_keep all ones, and emit no extra empty word.
REQ-022 SHALL keep m_keep all ones and m_last 0 on every non-final word.
REQ-023 SHALL hold m_data, m_keep and m_last stable while m_valid && !m_ready.
REQ-024 SHALL never overflow or underflow FILL; the bench flags any FILL > BUF_B as an error.
REQ-025 SHALL handle IN_W == OUT_W as a registered pass-through with identical last and keep semantics.

Reset
REQ-026 SHALL on reset set state=FILL, FILL=0, m_valid=0, m_last=0, m_keep=0, m_data=0, and s_ready=0 during reset, then 1 on the first cycle after release.
REQ-027 SHALL discard buffered bytes on reset asserted mid-frame, without emitting a partial word or m_last.

Configuration
REQ-028 SHALL, with GEARBOX_GENERIC_RST_SYNC_EN defined, route reset through a 2-flop synchroniser (asynchronous assert, synchronous release on clk), so release takes effect 2 clk edges after reset falls.
REQ-029 SHALL, without GEARBOX_GENERIC_RST_SYNC_EN, use reset directly as the asynchronous reset of all flops.

Structure
REQ-030 SHALL place the state encoding (FILL, FLUSH) and a byte-count-to-keep-mask function in package gearbox_pkg.
REQ-031 SHALL implement the synchroniser as sub-module gearbox_rst_sync, instantiated only under the macro.

Verification
REQ-032 SHALL verify 24->32, inputs 0x030201, 0x060504, 0x090807, 0x0C0B0A (last) -> outputs 0x04030201, 0x08070605, 0x0C0B0A09 with m_last on the third word and keep 0xF on every word.
REQ-033 SHALL verify 24->32, single input 0x030201 with last -> one output 0x00030201, keep 0x7, m_last=1.
REQ-034 SHALL verify 24->32, inputs 0x030201, 0x060504 (last) -> outputs 0x04030201 keep 0xF, then 0x00000605 keep 0x3 with m_last=1.
REQ-035 SHALL verify 32->24, input 0x04030201 with last -> outputs 0x030201 keep 0x7, then 0x000004 keep 0x1 with m_last=1.
REQ-036 SHALL verify that with m_ready low for 5 cycles and continuous s_valid, s_ready drops once FILL+3 > 7 bytes, m_data is held constant, and no byte is lost or duplicated after m_ready rises.
REQ-037 SHALL verify that reset asserted after two input words of a frame gives m_valid=0 and FILL=0, and that the next frame's first output is formed from new bytes only.
